tone_synth: RTL and testbench

TONE_SYNTH -- requirements
Module: tone_synth

---
 rtl/tone_synth_pkg.sv | 24 ++
 rtl/tone_synth_div.sv | 66 ++++++
 rtl/tone_synth.sv | 160 ++++++++++++++++
 tb/tb_tone_synth.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_synth_pkg.sv
// tone_synth_pkg: shared types and fixed-point constants for the tone synthesizer.
package tone_synth_pkg;

    // Output sample width; midscale is the "silent" level of the unsigned sample.
    localparam int SIG_WIDTH = 9;
    localparam logic [SIG_WIDTH-1:0] MIDSCALE = 9'd256;

    // Fractional bits of the [31:16].[15:0] frequency word.
    localparam int DEC_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SILENT = 2'd3
    } wave_t;

endpackage

// File: rtl/tone_synth_div.sv
// tone_synth_div: serial restoring divider, one quotient bit per clock.
// A start loads the operands; valid_out pulses once when the quotient is final.
module tone_synth_div #(
    parameter int WIDTH = 48
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] quotient_out,
    output logic             valid_out
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Shift the next dividend bit into the partial remainder and trial-subtract
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
    end

    // Iteration register: the quotient shifts in where the dividend shifts out
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (start_in) begin
                quo_q <= dividend_in;
                rem_q <= '0;
                dvs_q <= divisor_in;
                cnt_q <= CNT_W'(WIDTH);
                run_q <= 1'b1;
            end else if (run_q) begin
                if (!diff[WIDTH]) begin
                    rem_q <= diff[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= rem_sh[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    run_q     <= 1'b0;
                    valid_out <= 1'b1;
                end
            end
        end
    end

    assign quotient_out = quo_q;

endmodule

// File: rtl/tone_synth.sv
// tone_synth: phase-accumulator tone generator. A sample strobe advances the
// phase by an increment derived from the requested frequency; the increment
// is computed off the sample path by a serial divider, so the old tone keeps
// playing uninterrupted while a new frequency is being worked out.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | after reset, no frequency accepted yet (inc = 0, silent)
//   COMPUTE | divider busy on a new increment; f_in not accepted
//   RUN     | increment valid (possibly 0 = silent); f_in accepted
module tone_synth
    import tone_synth_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CLK_FREQ    = 100_000_000,
    parameter int SAMPLE_RATE = 8000,
    parameter int F_MAX       = 1000,
    parameter int PHASE_WIDTH = 24
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     f_in,
    input  logic                 f_in_valid,
    output logic                 f_in_ready,
    input  logic [1:0]           wave_sel,
    output logic [SIG_WIDTH-1:0] sig_out,
    output logic                 sig_out_valid,
    output logic                 busy_out
);
    localparam int STROBE_MAX = CLK_FREQ / SAMPLE_RATE - 1;
    localparam int CNT_W      = $clog2(STROBE_MAX + 1);
    localparam int DIV_W      = 48;
    localparam int SHIFT      = PHASE_WIDTH - DEC_WIDTH;
    localparam int PAD        = DIV_W - WIDTH - SHIFT;
    localparam int MSB        = PHASE_WIDTH - 1;

    state_t                 state_q, state_d;
    logic                   ready_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   strobe;
    logic [PHASE_WIDTH-1:0] phase_q, inc_q, phase_nxt;
    logic                   xfer, f_reject;
    logic                   div_start, inc_clr, inc_load;
    logic [DIV_W-1:0]       div_q;
    logic                   div_valid;
    logic [SIG_WIDTH-1:0]   sample_d, tri_bits;
    logic                   div_unused;

    assign strobe     = (cnt_q == CNT_W'(STROBE_MAX));
    assign f_in_ready = ready_q && (state_q != ST_COMPUTE);
    assign busy_out   = (state_q == ST_COMPUTE);
    assign xfer       = f_in_valid && f_in_ready;
    assign f_reject   = (f_in == '0) ||
                        (f_in[WIDTH-1:DEC_WIDTH] >= (WIDTH-DEC_WIDTH)'(F_MAX + 1));
    assign phase_nxt  = phase_q + inc_q;
    assign div_unused = ^div_q[DIV_W-1:PHASE_WIDTH];

    tone_synth_div #(
        .WIDTH(DIV_W)
    ) u_div (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (div_start),
        .dividend_in ({{PAD{1'b0}}, f_in, {SHIFT{1'b0}}}),
        .divisor_in  (DIV_W'(SAMPLE_RATE)),
        .quotient_out(div_q),
        .valid_out   (div_valid)
    );

    // Next-state logic: out-of-range requests silence the tone without a divide
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        inc_clr   = 1'b0;
        inc_load  = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (xfer) begin
                    if (f_reject) begin
                        inc_clr = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        div_start = 1'b1;
                        state_d   = ST_COMPUTE;
                    end
                end
            end
            ST_COMPUTE: begin
                if (div_valid) begin
                    inc_load = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; ready_q holds f_in_ready low until the first clock after reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
        end
    end

    // Free-running sample strobe counter, wraps at the terminal count
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else if (strobe) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Phase increment; a coincident strobe still sees the old value this cycle
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            inc_q <= '0;
        end else if (inc_clr) begin
            inc_q <= '0;
        end else if (inc_load) begin
            inc_q <= div_q[PHASE_WIDTH-1:0];
        end
    end

    // Waveform shaping of the phase the current strobe is about to store
    always_comb begin
        tri_bits = phase_nxt[MSB-1 -: SIG_WIDTH];
        sample_d = MIDSCALE;
        if (inc_q != '0) begin
            case (wave_sel)
                WAVE_SQUARE: sample_d = phase_nxt[MSB] ? '1 : '0;
                WAVE_SAW:    sample_d = phase_nxt[MSB -: SIG_WIDTH];
                WAVE_TRI:    sample_d = phase_nxt[MSB] ? ~tri_bits : tri_bits;
                default:     sample_d = MIDSCALE;
            endcase
        end
    end

    // Phase accumulator and registered sample output, both advanced by the strobe
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            phase_q       <= '0;
            sig_out       <= MIDSCALE;
            sig_out_valid <= 1'b0;
        end else begin
            sig_out_valid <= strobe;
            if (strobe) begin
                phase_q <= phase_nxt;
                sig_out <= sample_d;
            end
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: directed bench. "dut" runs a 20-cycle sample period so many
// samples fit in a short run; "dut_full" uses the real 12500-cycle period and
// shares all inputs, so it sees the same frequency traffic.
module tb_tone_synth;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] f_in;
    logic        f_in_valid;
    logic [1:0]  wave_sel;

    logic        f_in_ready, sig_out_valid, busy_out;
    logic [8:0]  sig_out;
    logic        full_ready, full_valid, full_busy;
    logic [8:0]  full_sig;

    int n_cmp = 0;
    int n_bad = 0;
    int full_cnt = 0;

    always #5 clk_in = ~clk_in;

    tone_synth #(.CLK_FREQ(160_000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .f_in(f_in), .f_in_valid(f_in_valid),
        .f_in_ready(f_in_ready), .wave_sel(wave_sel), .sig_out(sig_out),
        .sig_out_valid(sig_out_valid), .busy_out(busy_out)
    );

    tone_synth dut_full (
        .clk_in(clk_in), .rst_in(rst_in), .f_in(f_in), .f_in_valid(f_in_valid),
        .f_in_ready(full_ready), .wave_sel(wave_sel), .sig_out(full_sig),
        .sig_out_valid(full_valid), .busy_out(full_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_sample(input logic [23:0] p, input logic [1:0] w,
                                              input logic [23:0] inc);
        logic [8:0] t;
        t = p[22:14];
        if (w == 2'd3 || inc == 24'd0) return 9'd256;
        case (w)
            2'd0:    return p[23] ? 9'd511 : 9'd0;
            2'd1:    return p[23:15];
            default: return p[23] ? ~t : t;
        endcase
    endfunction

    function automatic logic [23:0] inc_of(input logic [31:0] f);
        logic [63:0] t;
        t = {32'd0, f} << 8;
        t = t / 64'd8000;
        return t[23:0];
    endfunction

    // Reference phase model for the fast instance, fed only by the bench's own stimulus
    logic [23:0] m_phase, m_inc, m_pend;
    logic        xfer_q, busy_q;
    logic [31:0] xf_val;
    logic [1:0]  wave_q;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            m_phase = '0; m_inc = '0; m_pend = '0;
            xfer_q = 1'b0; busy_q = 1'b0; xf_val = '0; wave_q = wave_sel;
        end else begin
            if (sig_out_valid) begin
                m_phase = m_phase + m_inc;
                check("sample", sig_out, exp_sample(m_phase, wave_q, m_inc));
            end
            if (xfer_q) begin
                if (xf_val == 32'd0 || xf_val[31:16] > 16'd1000) m_inc = '0;
                else m_pend = inc_of(xf_val);
            end
            if (busy_q && !busy_out) m_inc = m_pend;
            busy_q = busy_out;
            xfer_q = f_in_valid && f_in_ready;
            xf_val = f_in;
            wave_q = wave_sel;
        end
    end

    // Strobe spacing of both instances; release lands just after an edge, so
    // the first counting edge is the next one (start from -1)
    int gap_f, gap_s;
    always @(negedge clk_in) begin
        if (!rst_in) begin
            gap_f = -1;
            gap_s = -1;
        end else begin
            gap_f++;
            gap_s++;
            if (full_valid) begin
                check("full_spacing", gap_f, 12500);
                gap_f = 0;
                full_cnt++;
            end
            if (sig_out_valid) begin
                check("fast_spacing", gap_s, 20);
                gap_s = 0;
            end
        end
    end

    task automatic send(input logic [31:0] f);
        @(posedge clk_in); #1;
        f_in = f;
        f_in_valid = 1'b1;
        @(posedge clk_in); #1;
        f_in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (!sig_out_valid && k < 60);
        check({tag, "_valid_seen"}, sig_out_valid, 1);
    endtask

    task automatic wait_busy_fall(input string tag, output logic rdy_seen);
        int k = 0;
        rdy_seen = 1'b0;
        while (busy_out && k < 100) begin
            rdy_seen |= f_in_ready;
            @(negedge clk_in);
            k++;
        end
        check({tag, "_busy_fall"}, busy_out, 0);
    endtask

    task automatic wait_full(input int target);
        int k = 0;
        while (full_cnt < target && k < 13000) begin
            @(negedge clk_in);
            k++;
        end
        check("full_valid_seen", full_cnt >= target, 1);
    endtask

    task automatic reject_case(input string tag, input logic [31:0] f);
        logic b;
        send(f);
        @(negedge clk_in);
        check({tag, "_inc_zero"}, dut.inc_q, 0);
        b = busy_out;
        repeat (30) begin
            @(negedge clk_in);
            b |= busy_out;
        end
        check({tag, "_never_busy"}, b, 0);
        wait_valid(tag);
        check({tag, "_mid"}, sig_out, 256);
    endtask

    logic [8:0] sq_exp [8] = '{9'd0, 9'd0, 9'd0, 9'd511, 9'd511, 9'd511, 9'd511, 9'd0};

    initial begin
        logic       rdy;
        logic [8:0] prev;
        int         last_wrap, wraps, base;

        rst_in = 1'b0; f_in = '0; f_in_valid = 1'b0; wave_sel = 2'd0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_ready", f_in_ready, 0);
        check("rst_busy", busy_out, 0);
        check("rst_sig", sig_out, 256);
        check("rst_valid", sig_out_valid, 0);
        check("rst_full_sig", full_sig, 256);
        check("rst_full_ready", full_ready, 0);

        @(posedge clk_in); #1 rst_in = 1'b1;
        @(negedge clk_in);
        check("ready_before_edge", f_in_ready, 0);
        @(negedge clk_in);
        check("ready_first_edge", f_in_ready, 1);
        check("full_ready_first_edge", full_ready, 1);
        check("idle_not_busy", full_busy, 0);

        wait_valid("idle");
        check("idle_mid", sig_out, 256);

        // 1000 Hz square from phase 0
        send(32'h03E8_0000);
        @(negedge clk_in);
        check("k1_busy", busy_out, 1);
        check("k1_ready_low", f_in_ready, 0);
        wait_busy_fall("k1", rdy);
        check("k1_inc", dut.inc_q, 2097152);
        for (int i = 0; i < 8; i++) begin
            wait_valid("k1_sq");
            check("k1_square", sig_out, sq_exp[i]);
        end

        // retune to 440 Hz while running
        send(32'h01B8_0000);
        @(negedge clk_in);
        check("f440_busy", busy_out, 1);
        wait_busy_fall("f440", rdy);
        check("f440_ready_in_compute", rdy, 0);
        check("f440_inc", dut.inc_q, 922746);

        @(posedge clk_in); #1 wave_sel = 2'd1;
        wait_valid("saw_prime");
        prev = sig_out; last_wrap = -1; wraps = 0;
        for (int i = 1; i <= 60; i++) begin
            wait_valid("saw");
            if (sig_out < prev) begin
                if (last_wrap >= 0)
                    check("saw_period", (i - last_wrap == 18) || (i - last_wrap == 19), 1);
                last_wrap = i;
                wraps++;
            end
            prev = sig_out;
        end
        check("saw_wraps", wraps >= 3, 1);

        @(posedge clk_in); #1 wave_sel = 2'd2;
        repeat (10) wait_valid("tri");
        check("tri_inc_held", dut.inc_q, 922746);

        @(posedge clk_in); #1 wave_sel = 2'd3;
        wait_valid("sel3_prime");
        wait_valid("sel3");
        check("sel3_mid", sig_out, 256);
        @(posedge clk_in); #1 wave_sel = 2'd0;

        // just under the limit is accepted
        send(32'h03E8_FFFF);
        @(negedge clk_in);
        check("edge_ok_busy", busy_out, 1);
        wait_busy_fall("edge_ok", rdy);
        check("edge_ok_inc", dut.inc_q, 2099249);
        repeat (4) wait_valid("edge_ok_run");

        reject_case("rej_1001", 32'h03E9_0000);
        reject_case("rej_2000", 32'h07D0_0000);
        reject_case("rej_zero", 32'h0000_0000);

        // reset during COMPUTE
        wait_full(1);
        base = full_cnt;
        send(32'h01B8_0000);
        @(negedge clk_in);
        check("abort_busy", busy_out, 1);
        repeat (5) @(negedge clk_in);
        @(posedge clk_in); #1 rst_in = 1'b0;
        @(negedge clk_in);
        check("abort_ready", f_in_ready, 0);
        check("abort_busy_low", busy_out, 0);
        check("abort_sig", sig_out, 256);
        check("abort_valid", sig_out_valid, 0);
        check("abort_inc", dut.inc_q, 0);
        check("abort_full_busy", full_busy, 0);
        @(posedge clk_in); #1 rst_in = 1'b1;
        rdy = 1'b0;
        repeat (80) begin
            @(negedge clk_in);
            rdy |= busy_out;
        end
        check("abort_no_busy", rdy, 0);
        check("abort_no_late_inc", dut.inc_q, 0);
        wait_full(base + 1);
        wait_full(base + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        n_bad++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
